cache_repl_ctrl: RTL
====================

Name: cache_repl_ctrl

Overview:
- Replacement/allocation controller for the 4-way set-associative cache in the M stage.
- Owns per-set valid bits and a true-LRU rank order for each set.
- Services hit-touch requests in a single cycle and sequences misses: picks a victim, handshakes with the fill engine, then commits the allocation.
- Also accepts way invalidations.

Parameters:
- NSETS, 8, number of cache sets.
- SETW, 3, set index width; must equal log2(NSETS).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  1  access request valid.
- req_ready  out  1  controller can accept a request this cycle.
- req_set  in  SETW  set index of the access.
- req_hit  in  1  1 = hit in req_way; 0 = miss, allocate.
- req_way  in  2  hit way; ignored on a miss.
- inv_valid  in  1  invalidate request.
- inv_ready  out  1  invalidate accepted this cycle.
- inv_set  in  SETW  set to invalidate.
- inv_way  in  2  way to invalidate.
- fill_req  out  1  fill request to the fill engine.
- fill_ack  in  1  fill engine accepted fill_req.
- fill_set  out  SETW  set being filled.
- fill_way  out  2  victim way being filled.
- fill_done  in  1  fill data written.
- resp_valid  out  1  one-cycle response pulse.
- resp_way  out  2  way touched or allocated.
- resp_miss  out  1  response was for a miss.

Behaviour:
- State per set:
  - valid[3:0].
  - rank[w] (2 bits) for each way; the ranks are always a permutation of 0..3. Rank 0 = MRU, rank 3 = LRU.
- Reset (rst=0 at an edge):
  - all valid=0; rank[w]=w in every set.
  - FSM=IDLE.
  - fill_req=0, resp_valid=0, resp_miss=0, resp_way=0, fill_set=0, fill_way=0.
  - Reset mid-fill aborts the fill. fill_req is low from the next cycle; no response is issued.
- Touch(way w, set s), applied at the edge:
  - every way with rank < rank[w] increments its rank.
  - rank[w] becomes 0.
- Demote(w, s), applied at the edge:
  - every way with rank > rank[w] decrements its rank.
  - rank[w] becomes 3.
- Victim(s):
  - the lowest-index way with valid=0;
  - if all four ways are valid, the way with rank 3.
- FSM states: IDLE, FILL_REQ, FILL_WAIT, RESP.
- IDLE:
  - inv_ready=1. req_ready = !inv_valid, so an invalidate has priority over a request in the same cycle.
  - Invalidate: valid[inv_way] is cleared and Demote(inv_way) is applied at the edge. No response is issued.
  - Accepted hit: Touch(req_way) at the edge. Next cycle: resp_valid=1, resp_miss=0, resp_way=req_way. The FSM stays in IDLE, so back-to-back hits are allowed at one per cycle.
  - Hit to an invalid way (protocol error): ranks update as normal; valid is unchanged.
  - Accepted miss: fill_set and fill_way are latched, with fill_way = Victim(req_set) evaluated on the pre-edge state. Transition to FILL_REQ.
- FILL_REQ:
  - req_ready=0, inv_ready=0, fill_req=1.
  - fill_ack=1 moves to FILL_WAIT.
  - fill_ack=1 together with fill_done=1 in the same cycle performs the commit (see FILL_WAIT) and moves directly to RESP.
- FILL_WAIT:
  - fill_req=0; requests and invalidates are held off.
  - fill_done=1 commits at the edge: valid[fill_way]=1 and Touch(fill_way) in fill_set. Transition to RESP.
  - fill_done sampled in any other state is ignored.
- RESP:
  - resp_valid=1, resp_miss=1, resp_way=fill_way, for one cycle.
  - req_ready=0. Transition to IDLE.
- Latency:
  - hit: response 1 cycle after acceptance.
  - miss: response 1 cycle after the fill_done edge.
- fill_set and fill_way hold steady from the miss acceptance until the FSM returns to IDLE.
- resp_valid is 0 in every cycle not listed above.

Test Plan:
- Reset, then a miss to set 2 → fill_way=0, fill_req high until fill_ack. fill_done → resp_valid, resp_miss=1, resp_way=0. Set 2 ends with valid=0001, rank={0,1,2,3}.
- Four misses to set 5 → victims 0,1,2,3 in order. A fifth miss → victim 0, the LRU way. Hit way 0 then a miss → victim 1.
- Back-to-back hits to set 1, ways 3,2,3 on consecutive cycles → three resp_valid pulses with resp_way 3,2,3. Final ranks: w3=0, w2=1, w0=2, w1=3.
- inv_valid and req_valid in the same IDLE cycle → req_ready=0, invalidate applied; the invalidated way is the victim of the next miss to that set.
- fill_ack and fill_done in the same cycle in FILL_REQ → FILL_WAIT skipped; resp_valid appears 1 cycle later.
- rst=0 during FILL_WAIT → next cycle fill_req=0 and FSM in IDLE. No resp_valid pulse. All sets valid=0; the next miss in any set gets victim 0.

Source files
------------

// File: rtl/cache_repl_ctrl.sv
// -----------------------------------------------------------------------------
// cache_repl_ctrl
// Replacement and allocation controller for a 4-way set-associative cache.
// Keeps a valid bit and a true-LRU rank (0 = MRU, 3 = LRU) for every way of
// every set. Hits are serviced in a single cycle. A miss picks a victim,
// handshakes with the fill engine, commits the allocation, and then responds.
// Way invalidations are also accepted.
//
// Ports:
//   clk_i                      clock; all state updates on the rising edge
//   rst_i                      synchronous reset, active low
//   req_valid_i / req_ready_o  access request handshake
//   req_set_i, req_hit_i,      set index, hit flag, and hit way of the access
//   req_way_i
//   inv_valid_i / inv_ready_o  invalidate handshake
//   inv_set_i, inv_way_i       set and way to invalidate
//   fill_req_o / fill_ack_i    fill request handshake with the fill engine
//   fill_set_o, fill_way_o     set and victim way being filled
//   fill_done_i                fill data has been written
//   resp_valid_o               one-cycle response pulse
//   resp_way_o, resp_miss_o    way touched/allocated; response was a miss
// -----------------------------------------------------------------------------
module cache_repl_ctrl #(
    parameter int NSETS = 8,
    parameter int SETW  = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [SETW-1:0] req_set_i,
    input  logic            req_hit_i,
    input  logic [1:0]      req_way_i,
    input  logic            inv_valid_i,
    output logic            inv_ready_o,
    input  logic [SETW-1:0] inv_set_i,
    input  logic [1:0]      inv_way_i,
    output logic            fill_req_o,
    input  logic            fill_ack_i,
    output logic [SETW-1:0] fill_set_o,
    output logic [1:0]      fill_way_o,
    input  logic            fill_done_i,
    output logic            resp_valid_o,
    output logic [1:0]      resp_way_o,
    output logic            resp_miss_o
);

    typedef enum logic [1:0] {IDLE, FILL_REQ, FILL_WAIT, RESP} state_e;

    state_e                     state_q, state_d;
    logic [NSETS-1:0][3:0]      valid_q;
    logic [NSETS-1:0][3:0][1:0] rank_q;
    logic [SETW-1:0]            fill_set_q, fill_set_d;
    logic [1:0]                 fill_way_q, fill_way_d;
    logic                       resp_valid_q, resp_valid_d;
    logic [1:0]                 resp_way_q, resp_way_d;
    logic                       resp_miss_q, resp_miss_d;

    logic                       inv_accept, hit_accept, miss_accept, commit;
    logic [1:0]                 victim;
    logic [3:0]                 vic_valid;
    logic [3:0][1:0]            vic_rank;
    logic                       do_touch, do_demote;
    logic [SETW-1:0]            op_set;
    logic [1:0]                 op_way;
    logic [3:0][1:0]            op_rank, rank_upd;

    // An invalidate takes priority over a request in the same IDLE cycle.
    assign inv_accept  = (state_q == IDLE) && inv_valid_i;
    assign hit_accept  = req_valid_i && req_ready_o && req_hit_i;
    assign miss_accept = req_valid_i && req_ready_o && !req_hit_i;
    assign commit      = fill_done_i &&
                         ((state_q == FILL_WAIT) || ((state_q == FILL_REQ) && fill_ack_i));

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (miss_accept) state_d = FILL_REQ;
            FILL_REQ:  if (fill_ack_i)  state_d = fill_done_i ? RESP : FILL_WAIT;
            FILL_WAIT: if (fill_done_i) state_d = RESP;
            RESP:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        req_ready_o = (state_q == IDLE) && !inv_valid_i;
        inv_ready_o = (state_q == IDLE);
        fill_req_o  = (state_q == FILL_REQ);
    end

    // Victim: the lowest-index invalid way, or the LRU way when the set is full.
    // Scanning downward lets the lowest invalid index win.
    always_comb begin
        victim    = 2'd0;
        vic_valid = valid_q[req_set_i];
        vic_rank  = rank_q[req_set_i];
        if (&vic_valid) begin
            for (int w = 0; w < 4; w++) begin
                if (vic_rank[w] == 2'd3) victim = 2'(w);
            end
        end else begin
            for (int w = 3; w >= 0; w--) begin
                if (!vic_valid[w]) victim = 2'(w);
            end
        end
    end

    // At most one rank operation per cycle: invalidate (demote), hit (touch)
    // or fill commit (touch). Only the addressed set is rewritten.
    always_comb begin
        do_touch  = 1'b0;
        do_demote = 1'b0;
        op_set    = '0;
        op_way    = '0;
        if (inv_accept) begin
            do_demote = 1'b1;
            op_set    = inv_set_i;
            op_way    = inv_way_i;
        end else if (hit_accept) begin
            do_touch  = 1'b1;
            op_set    = req_set_i;
            op_way    = req_way_i;
        end else if (commit) begin
            do_touch  = 1'b1;
            op_set    = fill_set_q;
            op_way    = fill_way_q;
        end
        op_rank  = rank_q[op_set];
        rank_upd = op_rank;
        for (int w = 0; w < 4; w++) begin
            if (op_way == 2'(w)) begin
                rank_upd[w] = do_touch ? 2'd0 : 2'd3;
            end else if (do_touch && (op_rank[w] < op_rank[op_way])) begin
                rank_upd[w] = op_rank[w] + 2'd1;
            end else if (do_demote && (op_rank[w] > op_rank[op_way])) begin
                rank_upd[w] = op_rank[w] - 2'd1;
            end
        end
    end

    // Per-set valid bits and ranks; reset leaves every set empty with rank[w] = w.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            rank_q  <= {NSETS{8'b11_10_01_00}};
        end else begin
            if (do_touch || do_demote) begin
                rank_q[op_set] <= rank_upd;
            end
            if (inv_accept) begin
                valid_q[inv_set_i][inv_way_i] <= 1'b0;
            end else if (commit) begin
                valid_q[fill_set_q][fill_way_q] <= 1'b1;
            end
        end
    end

    // Fill target is latched only when a miss is accepted, so it holds steady
    // for the whole fill sequence. The response registers pulse one cycle
    // after a hit acceptance or a fill commit.
    always_comb begin
        fill_set_d   = fill_set_q;
        fill_way_d   = fill_way_q;
        resp_valid_d = hit_accept || commit;
        resp_miss_d  = commit;
        resp_way_d   = resp_way_q;
        if (miss_accept) begin
            fill_set_d = req_set_i;
            fill_way_d = victim;
        end
        if (hit_accept) begin
            resp_way_d = req_way_i;
        end else if (commit) begin
            resp_way_d = fill_way_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            fill_set_q   <= '0;
            fill_way_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_way_q   <= '0;
            resp_miss_q  <= 1'b0;
        end else begin
            fill_set_q   <= fill_set_d;
            fill_way_q   <= fill_way_d;
            resp_valid_q <= resp_valid_d;
            resp_way_q   <= resp_way_d;
            resp_miss_q  <= resp_miss_d;
        end
    end

    assign fill_set_o   = fill_set_q;
    assign fill_way_o   = fill_way_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_way_o   = resp_way_q;
    assign resp_miss_o  = resp_miss_q;

endmodule
